// File: rtl/fq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fq_pkg : shared entry type, default widths and helpers for fetch_queue. Rev 1.0
// ---------------------------------------------------------------------------
package fq_pkg;

  localparam int FQ_XLEN     = 32;
  localparam int FQ_ECAUSE_W = 7;

  typedef struct packed {
    logic [FQ_XLEN-1:0]     pc;
    logic [FQ_XLEN-1:0]     inst;
    logic                   pred_taken;
    logic [FQ_XLEN-1:0]     pred_addr;
    logic                   is_exception;
    logic [FQ_ECAUSE_W-1:0] exception_cause;
  } fq_entry_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue_if : fetch-group input and head-window output bundle. Rev 1.0
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DEPTH    = 16,
  parameter int FETCH_W  = 2,
  parameter int ISSUE_W  = 2,
  parameter int XLEN     = 32,
  parameter int ECAUSE_W = 7
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DEQ_W = $clog2(ISSUE_W + 1);

  logic [FETCH_W-1:0]          in_valid;
  logic [FETCH_W*XLEN-1:0]     in_pc;
  logic [FETCH_W*XLEN-1:0]     in_inst;
  logic [FETCH_W-1:0]          in_pred_taken;
  logic [XLEN-1:0]             in_pred_addr;
  logic [FETCH_W-1:0]          in_is_exception;
  logic [FETCH_W*ECAUSE_W-1:0] in_exception_cause;
  logic                        in_ready;

  logic [ISSUE_W-1:0]          out_valid;
  logic [ISSUE_W*XLEN-1:0]     out_pc;
  logic [ISSUE_W*XLEN-1:0]     out_inst;
  logic [ISSUE_W*XLEN-1:0]     out_pred_addr;
  logic [ISSUE_W-1:0]          out_pred_taken;
  logic [ISSUE_W-1:0]          out_is_exception;
  logic [ISSUE_W*ECAUSE_W-1:0] out_exception_cause;
  logic [DEQ_W-1:0]            deq_num;
  logic [CNT_W-1:0]            count;

  modport master (
    output in_valid, in_pc, in_inst, in_pred_taken, in_pred_addr,
           in_is_exception, in_exception_cause, deq_num,
    input  in_ready, out_valid, out_pc, out_inst, out_pred_addr,
           out_pred_taken, out_is_exception, out_exception_cause, count
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_pred_taken, in_pred_addr,
           in_is_exception, in_exception_cause, deq_num,
    output in_ready, out_valid, out_pc, out_inst, out_pred_addr,
           out_pred_taken, out_is_exception, out_exception_cause, count
  );
endinterface
`default_nettype wire

// File: rtl/fq_compact.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fq_compact : fetch-group truncation and in-order compaction. Rev 1.0
// ---------------------------------------------------------------------------
module fq_compact import fq_pkg::*; #(
  parameter int FETCH_W = 2,
  parameter int KW      = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]             in_valid,
  input  logic [FETCH_W*FQ_XLEN-1:0]     in_pc,
  input  logic [FETCH_W*FQ_XLEN-1:0]     in_inst,
  input  logic [FETCH_W-1:0]             in_pred_taken,
  input  logic [FQ_XLEN-1:0]             in_pred_addr,
  input  logic [FETCH_W-1:0]             in_is_exception,
  input  logic [FETCH_W*FQ_ECAUSE_W-1:0] in_exception_cause,
  output fq_entry_t                      ent [FETCH_W],
  output logic [KW-1:0]                  k
);

  logic [FETCH_W-1:0] eff;

  always_comb begin
    int   pos;
    logic stop;
    pos  = 0;
    stop = 1'b0;
    eff  = '0;
    for (int j = 0; j < FETCH_W; j++) ent[j] = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      eff[i] = in_valid[i] & ~stop;
      if (eff[i]) begin
        ent[pos].pc              = in_pc[i*FQ_XLEN +: FQ_XLEN];
        ent[pos].inst            = in_inst[i*FQ_XLEN +: FQ_XLEN];
        ent[pos].pred_taken      = in_pred_taken[i];
        ent[pos].pred_addr       = in_pred_addr;
        ent[pos].is_exception    = in_is_exception[i];
        ent[pos].exception_cause = in_exception_cause[i*FQ_ECAUSE_W +: FQ_ECAUSE_W];
        pos = pos + 1;
      end
      // a taken branch or fault keeps itself but kills every younger slot
      if (in_valid[i] & (in_pred_taken[i] | in_is_exception[i])) stop = 1'b1;
    end
    k = KW'(popcount(32'(eff)));
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : multi-channel instruction buffer between fetch and decode. Rev 1.0
// ---------------------------------------------------------------------------
module fetch_queue import fq_pkg::*; #(
  parameter int DEPTH    = 16,
  parameter int FETCH_W  = 2,
  parameter int ISSUE_W  = 2,
  parameter int XLEN     = FQ_XLEN,
  parameter int ECAUSE_W = FQ_ECAUSE_W
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst,
  input  logic         flush,
  fetch_queue_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DEQ_W = $clog2(ISSUE_W + 1);
  localparam int KW    = $clog2(FETCH_W + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] count_w;
  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        mem_d [DEPTH];
  fq_entry_t        grp   [FETCH_W];
  logic [KW-1:0]    k;
  logic [DEQ_W-1:0] avail, deq_eff;
  logic             enq_fire;

  fq_compact #(.FETCH_W(FETCH_W)) u_compact (
    .in_valid          (bus.in_valid),
    .in_pc             (bus.in_pc),
    .in_inst           (bus.in_inst),
    .in_pred_taken     (bus.in_pred_taken),
    .in_pred_addr      (bus.in_pred_addr),
    .in_is_exception   (bus.in_is_exception),
    .in_exception_cause(bus.in_exception_cause),
    .ent               (grp),
    .k                 (k)
  );

  // the wrap bit makes tail-head the exact occupancy, including full
  assign count_w      = tail_q - head_q;
  assign bus.count    = CNT_W'(count_w);
  assign bus.in_ready = (DEPTH - int'(count_w)) >= FETCH_W;
  assign enq_fire     = bus.in_ready & ~flush;
  assign avail        = (count_w > PTR_W'(ISSUE_W)) ? DEQ_W'(ISSUE_W) : DEQ_W'(count_w);
  assign deq_eff      = (bus.deq_num > avail) ? avail : bus.deq_num;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      head_d = head_q + PTR_W'(deq_eff);
      if (enq_fire) begin
        tail_d = tail_q + PTR_W'(k);
        for (int j = 0; j < FETCH_W; j++) begin
          if (KW'(j) < k) mem_d[tail_q[IDX_W-1:0] + IDX_W'(j)] = grp[j];
        end
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // payload storage carries no reset; out_valid gates its visibility
  always_ff @(posedge cpu_clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_head
    fq_entry_t e;
    assign e = mem_q[head_q[IDX_W-1:0] + IDX_W'(i)];
    assign bus.out_valid[i]                              = count_w > PTR_W'(i);
    assign bus.out_pc[i*XLEN +: XLEN]                    = e.pc;
    assign bus.out_inst[i*XLEN +: XLEN]                  = e.inst;
    assign bus.out_pred_addr[i*XLEN +: XLEN]             = e.pred_addr;
    assign bus.out_pred_taken[i]                         = e.pred_taken;
    assign bus.out_is_exception[i]                       = e.is_exception;
    assign bus.out_exception_cause[i*ECAUSE_W +: ECAUSE_W] = e.exception_cause;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_queue : directed plus random checks of fetch_queue against a queue model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 16;
  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int XL    = 32;
  localparam int EW    = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW), .XLEN(XL), .ECAUSE_W(EW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW), .XLEN(XL), .ECAUSE_W(EW)) dut (
    .cpu_clk(clk),
    .cpu_rst(rst_n),
    .flush  (flush),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pa;
    logic        pt;
    logic        ex;
    logic [6:0]  cause;
  } ment_t;

  ment_t       mq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] pc_seq = 32'h1c00_0000;
  logic [31:0] saved;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_grp(input logic [1:0] v, input logic [1:0] pt, input logic [1:0] ex,
                         input logic [31:0] pa);
    for (int s = 0; s < FW; s++) begin
      bus.in_pc[s*XL +: XL]              = pc_seq + 32'(4 * s);
      bus.in_inst[s*XL +: XL]            = $urandom;
      bus.in_exception_cause[s*EW +: EW] = 7'($urandom);
    end
    pc_seq               = pc_seq + 32'd8;
    bus.in_valid         = v;
    bus.in_pred_taken    = pt;
    bus.in_is_exception  = ex;
    bus.in_pred_addr     = pa;
  endtask

  task automatic set_idle();
    bus.in_valid        = '0;
    bus.in_pred_taken   = '0;
    bus.in_is_exception = '0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 64'(bus.count), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(bus.in_ready), 64'((DEPTH - mq.size()) >= FW));
    for (int i = 0; i < IW; i++) begin
      chk({tag, ".valid"}, 64'(bus.out_valid[i]), 64'(mq.size() > i));
      if (i < mq.size()) begin
        chk({tag, ".pc"},    64'(bus.out_pc[i*XL +: XL]),        64'(mq[i].pc));
        chk({tag, ".inst"},  64'(bus.out_inst[i*XL +: XL]),      64'(mq[i].inst));
        chk({tag, ".paddr"}, 64'(bus.out_pred_addr[i*XL +: XL]), 64'(mq[i].pa));
        chk({tag, ".ptkn"},  64'(bus.out_pred_taken[i]),         64'(mq[i].pt));
        chk({tag, ".exc"},   64'(bus.out_is_exception[i]),       64'(mq[i].ex));
        chk({tag, ".cause"}, 64'(bus.out_exception_cause[i*EW +: EW]), 64'(mq[i].cause));
      end
    end
  endtask

  // one clock: model the queue from the rules, advance the DUT, compare
  task automatic step(input string tag);
    ment_t nq[$];
    int    nvalid;
    nvalid = int'(bus.out_valid[0]) + int'(bus.out_valid[1]);
    chk({tag, ".deq_legal"}, 64'(int'(bus.deq_num) <= nvalid), 64'd1);
    nq = mq;
    if (flush) begin
      nq.delete();
    end else begin
      bit rdy;
      rdy = (DEPTH - mq.size()) >= FW;
      for (int d = 0; d < int'(bus.deq_num); d++) void'(nq.pop_front());
      if (rdy) begin
        for (int s = 0; s < FW; s++) begin
          if (bus.in_valid[s]) begin
            ment_t e;
            e.pc    = bus.in_pc[s*XL +: XL];
            e.inst  = bus.in_inst[s*XL +: XL];
            e.pa    = bus.in_pred_addr;
            e.pt    = bus.in_pred_taken[s];
            e.ex    = bus.in_is_exception[s];
            e.cause = bus.in_exception_cause[s*EW +: EW];
            nq.push_back(e);
            if (e.pt | e.ex) break;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    mq = nq;
    check_state(tag);
  endtask

  task automatic drain();
    set_idle();
    for (int n = 0; n < 20 && mq.size() > 0; n++) begin
      bus.deq_num = 2'((mq.size() > IW) ? IW : mq.size());
      step("drain");
    end
    bus.deq_num = '0;
  endtask

  initial begin
    set_idle();
    bus.in_pc              = '0;
    bus.in_inst            = '0;
    bus.in_pred_addr       = '0;
    bus.in_exception_cause = '0;
    bus.deq_num            = '0;

    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst_n = 1'b1;

    // basic ordering
    pc_seq = 32'h1c00_0000;
    set_grp(2'b11, 2'b00, 2'b00, 32'h0);
    step("basic");
    chk("basic.ov",  64'(bus.out_valid), 64'h3);
    chk("basic.pc0", 64'(bus.out_pc[31:0]),  64'h1c00_0000);
    chk("basic.pc1", 64'(bus.out_pc[63:32]), 64'h1c00_0004);
    chk("basic.cnt", 64'(bus.count), 64'd2);
    drain();

    // predicted-taken truncation
    set_grp(2'b11, 2'b01, 2'b00, 32'h1c00_0100);
    step("trunc");
    chk("trunc.cnt", 64'(bus.count), 64'd1);
    chk("trunc.pt0", 64'(bus.out_pred_taken[0]), 64'd1);
    chk("trunc.pa0", 64'(bus.out_pred_addr[31:0]), 64'h1c00_0100);
    drain();

    // exception truncation
    set_grp(2'b11, 2'b00, 2'b01, 32'h0);
    bus.in_exception_cause[6:0] = 7'h08;
    step("exc");
    chk("exc.cnt",    64'(bus.count), 64'd1);
    chk("exc.cause0", 64'(bus.out_exception_cause[6:0]), 64'h08);
    drain();

    // fill to full, backpressure, then wrap
    for (int g = 0; g < 8; g++) begin
      set_grp(2'b11, 2'b00, 2'b00, $urandom);
      step("fill");
    end
    chk("full.cnt", 64'(bus.count), 64'd16);
    chk("full.rdy", 64'(bus.in_ready), 64'd0);
    set_grp(2'b11, 2'b00, 2'b00, $urandom);
    bus.deq_num = 2'd2;
    step("bp");
    chk("bp.cnt", 64'(bus.count), 64'd14);
    chk("bp.rdy", 64'(bus.in_ready), 64'd1);
    for (int r = 0; r < 4; r++) begin
      set_grp(2'b11, 2'b00, 2'b00, $urandom);
      step("wrap");
    end
    drain();

    // partial dequeue
    set_grp(2'b11, 2'b00, 2'b00, 32'h0);
    step("pd.a");
    set_grp(2'b01, 2'b00, 2'b00, 32'h0);
    step("pd.b");
    chk("pd.cnt3", 64'(bus.count), 64'd3);
    saved = bus.out_pc[63:32];
    set_idle();
    bus.deq_num = 2'd1;
    step("pd.c");
    chk("pd.shift", 64'(bus.out_pc[31:0]), 64'(saved));
    chk("pd.cnt2",  64'(bus.count), 64'd2);
    drain();

    // flush beats enqueue and dequeue
    set_grp(2'b11, 2'b00, 2'b00, 32'h0);
    step("fl.a");
    set_grp(2'b11, 2'b00, 2'b00, 32'h0);
    step("fl.b");
    set_grp(2'b01, 2'b00, 2'b00, 32'h0);
    step("fl.c");
    chk("fl.cnt5", 64'(bus.count), 64'd5);
    flush = 1'b1;
    set_grp(2'b11, 2'b00, 2'b00, 32'h0);
    bus.deq_num = 2'd2;
    step("flush");
    flush = 1'b0;
    chk("flush.cnt", 64'(bus.count), 64'd0);
    chk("flush.ov",  64'(bus.out_valid), 64'd0);
    chk("flush.rdy", 64'(bus.in_ready), 64'd1);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      int lim;
      flush = ($urandom_range(0, 39) == 0);
      set_grp(2'($urandom),
              {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
              {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
              $urandom);
      lim = (mq.size() > IW) ? IW : mq.size();
      bus.deq_num = 2'($urandom_range(0, lim));
      step("rand");
    end
    flush = 1'b0;
    bus.deq_num = '0;

    // asynchronous reset between edges
    set_grp(2'b11, 2'b00, 2'b00, 32'h0);
    step("ar.a");
    set_idle();
    step("ar.b");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.cnt", 64'(bus.count), 64'd0);
    chk("arst.ov",  64'(bus.out_valid), 64'd0);
    mq.delete();
    check_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    set_grp(2'b11, 2'b00, 2'b00, 32'h0);
    step("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
